// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch definitions.
// Instruction codes, status codes and fetch FSM states.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_OUT,
    ST_WAIT_PC,
    ST_HALTED
  } fetch_state_e;

endpackage

// File: rtl/y86_ilen_decode.sv
// Y86-64 instruction class decode from icode.
// Gives byte length and which optional fields follow byte 0.
module y86_ilen_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  output logic [3:0] len_o,
  output logic       need_regids_o,
  output logic       need_valc_o,
  output logic       invalid_o
);

  always_comb begin
    len_o         = 4'd1;
    need_regids_o = 1'b0;
    need_valc_o   = 1'b0;
    invalid_o     = 1'b0;
    unique case (icode_i)
      I_HALT, I_NOP, I_RET: begin
        len_o = 4'd1;
      end
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
        len_o         = 4'd2;
        need_regids_o = 1'b1;
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        len_o         = 4'd10;
        need_regids_o = 1'b1;
        need_valc_o   = 1'b1;
      end
      I_JXX, I_CALL: begin
        len_o       = 4'd9;
        need_valc_o = 1'b1;
      end
      default: begin
        invalid_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/y86_fetch_unit.sv
// Y86-64 sequential fetch stage.
// Byte-serial instruction fetch with valid/ready field output.
module y86_fetch_unit
  import y86_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  input  logic              mem_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        icode,
  output logic [3:0]        ifun,
  output logic [3:0]        rA,
  output logic [3:0]        rB,
  output logic [63:0]       valC,
  output logic [ADDR_W-1:0] valP,
  output logic [2:0]        stat,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] valp_q, valp_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        icode_q, icode_d;
  logic [3:0]        ifun_q, ifun_d;
  logic [7:0]        regb_q, regb_d;
  logic [63:0]       valc_q, valc_d;
  logic [2:0]        stat_q, stat_d;
  logic              req_q, req_d;

  logic       first_byte;
  logic [3:0] dec_icode;
  logic [3:0] dec_len;
  logic       dec_regids;
  logic       dec_valc;
  logic       dec_inv;
  logic [2:0] vsel;

  // Byte 0 is decoded straight off the bus so its own ack can end the fetch.
  assign first_byte = (state_q == ST_FETCH) && (idx_q == 4'd0);
  assign dec_icode  = first_byte ? mem_rdata[7:4] : icode_q;
  assign vsel       = 3'(idx_q - (dec_regids ? 4'd2 : 4'd1));

  y86_ilen_decode u_dec (
    .icode_i       (dec_icode),
    .len_o         (dec_len),
    .need_regids_o (dec_regids),
    .need_valc_o   (dec_valc),
    .invalid_o     (dec_inv)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valp_d  = valp_q;
    idx_d   = idx_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    regb_d  = regb_q;
    valc_d  = valc_q;
    stat_d  = stat_q;
    unique case (state_q)
      ST_FETCH: begin
        if (req_q && mem_ack) begin
          if (mem_err) begin
            stat_d  = S_ADR;
            valp_d  = pc_q + ADDR_W'(first_byte ? 4'd1 : dec_len);
            state_d = ST_OUT;
          end else begin
            idx_d = idx_q + 4'd1;
            if (first_byte) begin
              icode_d = mem_rdata[7:4];
              ifun_d  = mem_rdata[3:0];
            end else if (dec_regids && idx_q == 4'd1) begin
              regb_d = mem_rdata;
            end else if (dec_valc) begin
              valc_d[{vsel, 3'b000} +: 8] = mem_rdata;
            end
            if (idx_q == dec_len - 4'd1) begin
              state_d = ST_OUT;
              valp_d  = pc_q + ADDR_W'(dec_len);
              stat_d  = dec_inv ? S_INS :
                        (dec_icode == I_HALT) ? S_HLT : S_AOK;
            end
          end
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = (stat_q == S_AOK) ? ST_WAIT_PC : ST_HALTED;
        end
      end
      ST_WAIT_PC: begin
        if (pc_valid) begin
          pc_d    = pc_in;
          idx_d   = 4'd0;
          icode_d = 4'd0;
          ifun_d  = 4'd0;
          regb_d  = 8'hFF;
          valc_d  = '0;
          state_d = ST_FETCH;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
    endcase
    req_d = (state_d == ST_FETCH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      valp_q  <= '0;
      idx_q   <= 4'd0;
      icode_q <= 4'd0;
      ifun_q  <= 4'd0;
      regb_q  <= 8'hFF;
      valc_q  <= '0;
      stat_q  <= S_AOK;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valp_q  <= valp_d;
      idx_q   <= idx_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      regb_q  <= regb_d;
      valc_q  <= valc_d;
      stat_q  <= stat_d;
      req_q   <= req_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_addr  = pc_q + ADDR_W'(idx_q);
  assign out_valid = (state_q == ST_OUT);
  assign icode     = icode_q;
  assign ifun      = ifun_q;
  assign rA        = dec_regids ? regb_q[7:4] : REG_NONE;
  assign rB        = dec_regids ? regb_q[3:0] : REG_NONE;
  assign valC      = valc_q;
  assign valP      = valp_q;
  assign stat      = stat_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Scoreboard bench for y86_fetch_unit.
// Byte memory model with delayed acks, errors and output stalls.
module tb_y86_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_valid = 1'b0;
  logic [63:0] pc_in = '0;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        mem_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, pc;
  logic [2:0]  stat;

  always #5 clk = ~clk;

  y86_fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .pc_valid(pc_valid), .pc_in(pc_in),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .stat(stat), .pc(pc)
  );

  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, pc;
    logic [2:0]  stat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [7:0]  mem [logic [63:0]];
  int          errors = 0;
  int          checks = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          stall_left = 0;
  logic        err_en = 1'b0;
  logic [63:0] err_addr = '0;

  function automatic logic [7:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: instruction length table and field layout of Y86-64.
  function automatic exp_t model(input logic [63:0] p, input int eidx);
    exp_t        e;
    logic [7:0]  b0, rb;
    int          len, lim, pos;
    bit          regs, vc, inv, err;
    b0 = rd(p);
    regs = 0; vc = 0; inv = 0;
    case (b0[7:4])
      4'h0, 4'h1, 4'h9:       len = 1;
      4'h2, 4'h6, 4'hA, 4'hB: begin len = 2; regs = 1; end
      4'h3, 4'h4, 4'h5:       begin len = 10; regs = 1; vc = 1; end
      4'h7, 4'h8:             begin len = 9; vc = 1; end
      default:                begin len = 1; inv = 1; end
    endcase
    e.pc = p; e.icode = 0; e.ifun = 0;
    e.ra = 4'hF; e.rb = 4'hF; e.valc = 0;
    if (eidx == 0) begin
      e.stat = 3'd3;
      e.valp = p + 64'd1;
      return e;
    end
    e.icode = b0[7:4];
    e.ifun  = b0[3:0];
    err = (eidx > 0) && (eidx < len);
    lim = err ? eidx : len;
    if (regs && lim > 1) begin
      rb = rd(p + 64'd1);
      e.ra = rb[7:4];
      e.rb = rb[3:0];
    end
    for (int k = 0; k < 8; k++) begin
      pos = (regs ? 2 : 1) + k;
      if (vc && pos < lim) e.valc[8*k +: 8] = rd(p + 64'(pos));
    end
    e.stat = err ? 3'd3 : inv ? 3'd4 : (b0[7:4] == 4'h0) ? 3'd2 : 3'd1;
    e.valp = p + 64'(len);
    return e;
  endfunction

  // Memory responder: ack after ack_delay idle cycles.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    mem_err = 1'b0;
    mem_rdata = 8'h00;
    if (mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        wait_cnt = 0;
        if (err_en && mem_addr == err_addr) begin
          mem_err = 1'b1;
          mem_rdata = 8'($urandom);
        end else begin
          mem_rdata = rd(mem_addr);
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Monitor: compares every presented cycle, pops on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      out_ready = 1'b0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: pc=%0h icode=%0h", pc, icode);
        out_ready = 1'b1;
      end else begin
        mon_e = exp_q[0];
        chk("icode", 64'(icode), 64'(mon_e.icode));
        chk("ifun", 64'(ifun), 64'(mon_e.ifun));
        chk("rA", 64'(rA), 64'(mon_e.ra));
        chk("rB", 64'(rB), 64'(mon_e.rb));
        chk("valC", valC, mon_e.valc);
        chk("valP", valP, mon_e.valp);
        chk("stat", 64'(stat), 64'(mon_e.stat));
        chk("pc", pc, mon_e.pc);
        if (stall_left > 0) begin
          stall_left--;
          out_ready = 1'b0;
        end else begin
          out_ready = 1'b1;
        end
        if (out_ready) exp_q.delete(0);
      end
    end else begin
      out_ready = 1'b0;
    end
  end

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d instructions pending", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pc_valid = 1'b0;
    err_en = 1'b0;
    ack_delay = 0;
    stall_left = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pc", pc, 64'd0);
    chk("rst_stat", 64'(stat), 64'd1);
    chk("rst_icode", 64'(icode), 64'd0);
    chk("rst_rA", 64'(rA), 64'hF);
    chk("rst_rB", 64'(rB), 64'hF);
    chk("rst_valC", valC, 64'd0);
    chk("rst_valP", valP, 64'd0);
    exp_q.push_back(model(64'h0, -1));
    rst_n = 1'b1;
    @(negedge clk);
    chk("boot_req", 64'(mem_req), 64'd1);
    chk("boot_addr", mem_addr, 64'd0);
    wait_done();
  endtask

  task automatic check_halted(input logic [63:0] p);
    for (int i = 0; i < 6; i++) begin
      pc_valid = (i % 2 == 0);
      pc_in = 64'h40;
      @(negedge clk);
      chk("halt_req", 64'(mem_req), 64'd0);
      chk("halt_valid", 64'(out_valid), 64'd0);
      chk("halt_pc", pc, p);
    end
    pc_valid = 1'b0;
    do_reset();
  endtask

  task automatic issue(input logic [63:0] p, input logic [0:9][7:0] b,
                       input int dly, input int stall, input int eidx);
    exp_t e;
    int   lat, nb;
    for (int i = 0; i < 10; i++) mem[p + 64'(i)] = b[i];
    e = model(p, eidx);
    ack_delay = dly;
    err_en = (eidx >= 0);
    err_addr = p + 64'(eidx);
    stall_left = stall;
    exp_q.push_back(e);
    pc_valid = 1'b1;
    pc_in = p;
    @(negedge clk);
    pc_valid = 1'b0;
    pc_in = {$urandom, $urandom};
    chk("first_req", 64'(mem_req), 64'd1);
    chk("first_addr", mem_addr, p);
    lat = 1;
    while (!out_valid && lat < 600) begin
      @(negedge clk);
      lat++;
    end
    nb = (e.stat == 3'd3) ? eidx + 1 : int'(e.valp - p);
    if (dly == 0) chk("latency", 64'(lat), 64'(nb + 1));
    wait_done();
    if (e.stat != 3'd1) check_halted(p);
  endtask

  task automatic mid_reset();
    int n = 0;
    for (int i = 0; i < 10; i++) mem[64'h3000 + 64'(i)] = 8'(8'h30 + i);
    ack_delay = 0;
    err_en = 1'b0;
    pc_valid = 1'b1;
    pc_in = 64'h3000;
    @(negedge clk);
    pc_valid = 1'b0;
    while (!(mem_req && mem_addr == 64'h3004) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_addr", mem_addr, 64'h3004);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_req", 64'(mem_req), 64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    do_reset();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[64'h0] = 8'h10;
    do_reset();
    issue(64'h100, {8'h30, 8'hF3, 8'h08, 8'h07, 8'h06,
                    8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, 0, 0, -1);
    issue(64'h200, {8'h73, 8'h40, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 5, -1);
    issue(64'h40, {8'h10, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, -1);
    issue(64'hFFFF_FFFF_FFFF_FFFF,
          {8'h20, 8'h12, 8'h00, 8'h00, 8'h00,
           8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1, -1);
    issue(64'h300, {8'hC0, 8'h11, 8'h22, 8'h33, 8'h44,
                    8'h55, 8'h66, 8'h77, 8'h88, 8'h99}, 0, 0, -1);
    issue(64'h310, {8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                    8'h55, 8'h66, 8'h77, 8'h88, 8'h99}, 1, 2, -1);
    issue(64'h400, {8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 3);
    mid_reset();
    for (int i = 0; i < 40; i++) begin
      logic [0:9][7:0] rbytes;
      logic [63:0]     rp;
      int              ei;
      for (int k = 0; k < 10; k++) rbytes[k] = 8'($urandom);
      rp = {32'($urandom), 32'h1000_0000} | (64'(i) << 8);
      ei = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 9)) : -1;
      issue(rp, rbytes, int'($urandom_range(0, 2)),
            int'($urandom_range(0, 3)), ei);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/y86_fetch_unit.md
Name: y86_fetch_unit

Overview:
Sequential-processor fetch stage; consumes the next-PC value produced by the PC-update logic and produces icode/ifun/rA/rB/valC/valP for decode/execute.
- Holds the PC register.
- Reads instruction bytes one at a time over a byte-wide req/ack instruction-memory port.
- Assembles a complete Y86-64 instruction and offers it on a valid/ready output, then waits for the next PC.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
ADDR_W, 64, address/PC width; fixed at 64 for Y86-64

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  synchronous active-low reset
pc_valid  input  1  pc_in carries next PC (new_PC from PC update)
pc_in  input  64  next PC value
mem_req  output  1  byte read request
mem_addr  output  64  byte address, stable while mem_req high
mem_rdata  input  8  read byte, valid when mem_ack high
mem_ack  input  1  request completes this cycle; may assert in same cycle as mem_req
mem_err  input  1  with mem_ack: address invalid, mem_rdata ignored
out_valid  output  1  instruction fields valid
out_ready  input  1  consumer accepts
icode  output  4  byte0[7:4]
ifun  output  4  byte0[3:0]
rA  output  4  regid byte[7:4], else 4'hF
rB  output  4  regid byte[3:0], else 4'hF
valC  output  64  little-endian constant, else 0
valP  output  64  PC + instruction length, mod 2^64
stat  output  3  1=AOK 2=HLT 3=ADR 4=INS
pc  output  64  current PC

Behaviour:
- Reset (rst_n low at edge):
  - pc=RESET_PC; state=FETCH; byte index=0.
  - mem_req=0, out_valid=0, icode=ifun=0, rA=rB=4'hF, valC=0, valP=0, stat=1.
  - Reset mid-fetch abandons the transaction; an ack in the reset cycle is ignored; memory must tolerate a dropped request.
- States: FETCH, OUT, WAIT_PC, HALTED.
- FETCH:
  - mem_req=1, mem_addr=pc+idx (wraps mod 2^64).
  - On mem_ack, capture byte idx and increment idx.
  - Byte 0 fixes the length:
    - 1 byte: icode 0 (halt), 1 (nop), 9 (ret).
    - 2 bytes: icode 2, 6, A, B.
    - 10 bytes: icode 3, 4, 5.
    - 9 bytes: icode 7, 8.
    - icode C-F: invalid, length 1.
  - 10-byte instructions: byte1 is regids; bytes 2-9 are valC, byte2 = LSB.
  - 9-byte instructions: no regids; bytes 1-8 are valC.
  - After the last byte's ack, go to OUT next cycle; mem_req drops in that same edge.
  - Minimum latency: N cycles for N bytes with same-cycle ack, plus 1 cycle to out_valid.
- mem_err with mem_ack on any byte: stop fetching; stat=ADR; go to OUT. Fields captured so far are kept; the rest take defaults.
- OUT:
  - out_valid=1; all outputs held stable until out_ready.
  - valP = pc + length using the decoded length, even on ADR.
  - On out_valid&out_ready: stat AOK goes to WAIT_PC; stat HLT/ADR/INS goes to HALTED.
  - stat=HLT for icode 0; stat=INS for invalid icode.
- WAIT_PC: on pc_valid, pc<=pc_in, idx=0, go to FETCH. pc_valid is ignored in all other states.
- HALTED: no requests, out_valid=0; only reset exits.
- Register fields are combinationally defaulted from icode class, not from stale bytes.

Decomposition:
- Package y86_pkg holds:
  - icode constants (I_HALT..I_POPQ).
  - stat codes (S_AOK=1, S_HLT=2, S_ADR=3, S_INS=4).
  - FSM state enum.
- One combinational sub-module, y86_ilen_decode: takes icode and returns length (4 bits), need_regids, need_valC, invalid.

Test Plan:
- Reset with RESET_PC=0, same-cycle ack memory -> first mem_addr=0, pc=0, stat=1, out_valid=0.
- irmovq bytes 30 F3 08 07 06 05 04 03 02 01 at 0x100 -> icode=3, rA=F, rB=3, valC=64'h0102030405060708, valP=0x10A; out_valid 11 cycles after first req.
- jXX 73 + 8 bytes dest 0x40 at 0x200, ack delayed 2 cycles per byte, out_ready low 5 cycles -> valC=0x40, valP=0x209, outputs stable while stalled; pc_valid with 0x40 -> next mem_addr=0x40.
- rrmovq 20 12 at PC 64'hFFFF_FFFF_FFFF_FFFF -> byte-1 address 0, rA=1, rB=2, valP=1.
- Byte C0 -> stat=4, valP=pc+1; after handshake mem_req stays 0, pc_valid ignored. Byte 00 -> stat=2, same HALTED behaviour.
- call 80, mem_err on byte 3 -> stat=3, valP=pc+9, HALTED. Separately: rst_n low during byte 5 of a 10-byte fetch -> mem_req=0 next cycle, refetch from RESET_PC.
